// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-bit binary-to-one-hot decoder with enable,
// load strobe and an autonomous scan mode that walks the one-hot output
// through all 2^N lines, holding each line for DWELL cycles.
module decoder_n_scan #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      a,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST = '1;
    localparam logic [W-1:0]  LINE0    = W'(1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  idx_n;
    logic          wrap_n;
    logic [W-1:0]  y_n;

    // Next-state logic; priority is !en > load > mode change > dwell step.
    // Outputs are computed from the next state so y/idx/wrap appear one
    // cycle after the inputs that caused them.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (mode) begin
                        state_n = SCAN;
                        cnt_n   = '0;
                        if (load) idx_n = a;
                    end else if (load) begin
                        state_n = DIRECT;
                        idx_n   = a;
                    end
                end
            end
            DIRECT: begin
                if (!en) begin
                    state_n = IDLE;
                end else begin
                    if (load) idx_n = a;
                    if (mode) begin
                        state_n = SCAN;
                        cnt_n   = '0;
                    end
                end
            end
            SCAN: begin
                if (!en) begin
                    // counter and index freeze; counter restarts on re-entry
                    state_n = IDLE;
                end else if (load) begin
                    // a load pre-empts any dwell step due this cycle
                    idx_n = a;
                    cnt_n = '0;
                    if (!mode) state_n = DIRECT;
                end else if (!mode) begin
                    state_n = DIRECT;
                end else if (cnt == CNT_LAST) begin
                    cnt_n  = '0;
                    idx_n  = idx + N'(1);
                    wrap_n = (idx == IDX_LAST);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        y_n = (state_n == IDLE) ? '0 : (LINE0 << idx_n);
    end

    // State, counter and all outputs registered; async active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            y     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            y     <= y_n;
            wrap  <= wrap_n;
        end
    end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: a vector table for direct decode, hand-written
// multi-cycle sequences, and random stimulus against a behavioural model.
module tb_decoder_n_scan;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, load;
    logic [1:0] a;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;

    logic       en3, mode3, load3;
    logic [2:0] a3;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       wrap3;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model: 0 = idle, 1 = direct, 2 = scan
    int ms, mi, mc, mw;

    typedef struct {
        logic       en, mode, load;
        logic [1:0] a;
        logic [3:0] y;
        logic [1:0] idx;
        logic       wrap;
    } vec_t;
    vec_t tbl [8];

    decoder_n_scan #(.N(2), .DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .a(a), .y(y), .idx(idx), .wrap(wrap)
    );

    decoder_n_scan #(.N(3), .DWELL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .load(load3),
        .a(a3), .y(y3), .idx(idx3), .wrap(wrap3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; mi = 0; mc = 0; mw = 0;
    endtask

    // One clock of the spec rules applied to the current inputs.
    task automatic model_step();
        mw = 0;
        if (!en) begin
            ms = 0;
        end else if (ms == 0) begin
            if (mode) begin
                ms = 2; mc = 0;
                if (load) mi = int'(a);
            end else if (load) begin
                ms = 1; mi = int'(a);
            end
        end else if (ms == 1) begin
            if (load) mi = int'(a);
            if (mode) begin ms = 2; mc = 0; end
        end else begin
            if (load) begin
                mi = int'(a); mc = 0;
                if (!mode) ms = 1;
            end else if (!mode) begin
                ms = 1;
            end else begin
                mc = mc + 1;
                if (mc == DW) begin
                    mc = 0;
                    if (mi == 3) mw = 1;
                    mi = (mi + 1) % 4;
                end
            end
        end
    endtask

    // Advance one clock and compare the N=2 instance with the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_y", y, (ms == 0) ? 0 : (1 << mi));
        chk("model_idx", idx, mi);
        chk("model_wrap", wrap, mw);
        chk("onehot", ($countones(y) <= 1), 1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 2'd2, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 2'd2, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0};

        // reset held with en/mode active
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b0; a = '0;
        en3 = 1'b0; mode3 = 1'b0; load3 = 1'b0; a3 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", y, 0);
        chk("rst_idx", idx, 0);
        chk("rst_wrap", wrap, 0);
        rst_n = 1'b1;

        // full scan period from idx 0
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("scan_y", y, 1 << (k / DW));
            chk("scan_wrap", wrap, 0);
        end
        tick();
        chk("scan_wrap_y", y, 1);
        chk("scan_wrap_pulse", wrap, 1);
        tick();
        chk("scan_wrap_drop", wrap, 0);

        // direct decode table, including idle / hold cases
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; load = tbl[i].load; a = tbl[i].a;
            tick();
            chk("tbl_y", y, tbl[i].y);
            chk("tbl_idx", idx, tbl[i].idx);
            chk("tbl_wrap", wrap, tbl[i].wrap);
        end

        // load at counter=DWELL-1 on idx 1 pre-empts the step
        load = 1'b0; mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_pre_y", y, 4'b0010);
        end
        load = 1'b1; a = 2'd3;
        tick();
        chk("mid_load_y", y, 4'b1000);
        chk("mid_load_wrap", wrap, 0);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_hold_y", y, 4'b1000);
        end
        tick();
        chk("mid_wrap_y", y, 4'b0001);
        chk("mid_wrap_pulse", wrap, 1);

        // enable gap on idx 2
        for (int k = 0; k < 3; k++) tick();
        for (int k = 0; k < 4; k++) tick();
        tick();
        chk("gap_start_y", y, 4'b0100);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gap_y", y, 0);
            chk("gap_idx", idx, 2);
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("gap_resume_y", y, 4'b0100);
        end
        tick();
        chk("gap_next_y", y, 4'b1000);

        // asynchronous reset mid-scan, no edge in between
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y", y, 0);
        chk("arst_idx", idx, 0);
        chk("arst_wrap", wrap, 0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // random stimulus against the model
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom % 8) != 0;
            mode = ($urandom % 4) != 0;
            load = ($urandom % 6) == 0;
            a    = 2'($urandom);
            tick();
        end

        // N=3, DWELL=1 walk on the second instance
        en = 1'b0; mode = 1'b0; load = 1'b0;
        en3 = 1'b1; mode3 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            chk("n3_y", y3, 1 << ((idx3 == 3'((k) % 8)) ? (k % 8) : (k % 8)));
            chk("n3_idx", idx3, k % 8);
            chk("n3_wrap", wrap3, (k > 0 && (k % 8) == 0) ? 1 : 0);
            chk("n3_onehot", $countones(y3), 1);
        end
        en3 = 1'b0;
        @(posedge clk);
        #1;
        chk("n3_off_y", y3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
